// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter and its posted-write FIFO.
package dram_arb_pkg;

  localparam int ARB_ADDR_W = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  localparam logic [3:0] WE_READ = 4'h0;
  localparam logic [3:0] WE_FULL = 4'hF;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Registered synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module wb_fifo #(
  parameter int LOG = 2,
  parameter int W   = 68
) (
  input  logic         clk,
  input  logic         rst_x,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << LOG;

  logic [LOG:0]   wptr_q, wptr_d;
  logic [LOG:0]   rptr_q, rptr_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           do_push_s, do_pop_s;

  assign full_o    = (wptr_q[LOG] != rptr_q[LOG]) && (wptr_q[LOG-1:0] == rptr_q[LOG-1:0]);
  assign empty_o   = (wptr_q == rptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rptr_q[LOG-1:0]];

  // Pointer advance; pointers wrap naturally modulo 2*DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_s) begin
      wptr_d = wptr_q + {{LOG{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + {{LOG{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; cleared on reset so a discarded FIFO never exposes stale data.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wptr_q[LOG-1:0]] <= din_i;
    end else begin
      mem_q[wptr_q[LOG-1:0]] <= mem_q[wptr_q[LOG-1:0]];
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates the single DRAM command port between loader writes, posted CPU
// stores and one outstanding dcache miss read, returning fill data with its address.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int WB_LOG = 2,
  parameter int ADDR_W = ARB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_wdata,
  input  logic [3:0]        wr_be,
  output logic              wr_full,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [31:0]       fill_rdata,
  output logic              busy,
  output logic              err,
  output logic              dram_oe,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [31:0]       dram_wdata,
  output logic [3:0]        dram_we,
  input  logic [31:0]       dram_rdata,
  input  logic              dram_valid,
  input  logic              dram_busy
);

  arb_state_e        state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              err_q, err_d;

  wb_entry_t         wb_in_s, wb_head_s;
  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;

  assign wb_in_s     = '{addr: wr_addr, wdata: wr_wdata, be: wr_be};
  assign fifo_push_s = wr_req & ~fifo_full_s;
  assign wr_full     = fifo_full_s;
  assign busy        = rd_pend_q | (state_q == RD_WAIT);
  assign err         = err_q;
  assign fill_addr   = rd_addr_q;

  wb_fifo #(
    .LOG (WB_LOG),
    .W   ($bits(wb_entry_t))
  ) u_wb_fifo (
    .clk     (clk),
    .rst_x   (rst_x),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .din_i   (wb_in_s),
    .head_o  (wb_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Command selection, fill return and next-state logic.
  always_comb begin
    state_d    = state_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    err_d      = err_q;
    dram_oe    = 1'b0;
    dram_addr  = '0;
    dram_wdata = 32'h0;
    dram_we    = WE_READ;
    ld_ack     = 1'b0;
    fifo_pop_s = 1'b0;
    fill_valid = 1'b0;
    fill_rdata = 32'h0;

    case (state_q)
      IDLE: begin
        if (!dram_busy && ld_req) begin
          dram_oe    = 1'b1;
          dram_addr  = ld_addr;
          dram_wdata = ld_wdata;
          dram_we    = WE_FULL;
          ld_ack     = 1'b1;
        end else if (!dram_busy && !fifo_empty_s) begin
          dram_oe    = 1'b1;
          dram_addr  = wb_head_s.addr;
          dram_wdata = wb_head_s.wdata;
          dram_we    = wb_head_s.be;
          fifo_pop_s = 1'b1;
        end else if (!dram_busy && rd_pend_q) begin
          // FIFO is empty here, so every earlier store is already on the bus.
          dram_oe   = 1'b1;
          dram_addr = rd_addr_q;
          dram_we   = WE_READ;
          state_d   = RD_WAIT;
        end else begin
          dram_oe = 1'b0;
        end
        if (dram_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
      end
      RD_WAIT: begin
        if (dram_valid) begin
          fill_valid = 1'b1;
          fill_rdata = dram_rdata;
          rd_pend_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_req && fifo_full_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (rd_req && busy) begin
      err_d = 1'b1;
    end else if (rd_req) begin
      rd_pend_d = 1'b1;
      rd_addr_d = rd_addr;
    end else begin
      rd_pend_d = rd_pend_d;
    end
  end

  // State, pending-read and error registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter.
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        ld_req;
  logic [31:0] ld_addr, ld_wdata;
  logic        ld_ack;
  logic        wr_req;
  logic [31:0] wr_addr, wr_wdata;
  logic [3:0]  wr_be;
  logic        wr_full;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        fill_valid;
  logic [31:0] fill_addr, fill_rdata;
  logic        busy, err;
  logic        dram_oe;
  logic [31:0] dram_addr, dram_wdata;
  logic [3:0]  dram_we;
  logic [31:0] dram_rdata;
  logic        dram_valid, dram_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_port_arbiter #(.WB_LOG(2), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_ack     (ld_ack),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_wdata   (wr_wdata),
    .wr_be      (wr_be),
    .wr_full    (wr_full),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_rdata (fill_rdata),
    .busy       (busy),
    .err        (err),
    .dram_oe    (dram_oe),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_rdata (dram_rdata),
    .dram_valid (dram_valid),
    .dram_busy  (dram_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic oe, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] we);
    chk({tag, ".oe"}, 64'(dram_oe), 64'(oe));
    if (oe) begin
      chk({tag, ".addr"}, 64'(dram_addr), 64'(a));
      chk({tag, ".wdata"}, 64'(dram_wdata), 64'(d));
      chk({tag, ".we"}, 64'(dram_we), 64'(we));
    end
  endtask

  initial begin
    rst_x = 1'b0; ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    wr_req = 1'b0; wr_addr = 32'h0; wr_wdata = 32'h0; wr_be = 4'h0;
    rd_req = 1'b0; rd_addr = 32'h0; dram_rdata = 32'h0;
    dram_valid = 1'b0; dram_busy = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst.oe", 64'(dram_oe), 64'd0);
    chk("rst.full", 64'(wr_full), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.fill", 64'(fill_valid), 64'd0);
    chk("rst.ack", 64'(ld_ack), 64'd0);
    rst_x = 1'b1;
    tick();

    // Loader priority over a queued store
    dram_busy = 1'b1; wr_req = 1'b1; wr_addr = 32'h200; wr_wdata = 32'h11; wr_be = 4'h3;
    tick();
    wr_req = 1'b0; dram_busy = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEADBEEF;
    #1;
    chk_cmd("ld", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    chk("ld.ack", 64'(ld_ack), 64'd1);
    tick();
    ld_req = 1'b0;
    #1;
    chk_cmd("ld.st", 1'b1, 32'h200, 32'h11, 4'h3);
    chk("ld.st.ack", 64'(ld_ack), 64'd0);
    tick();
    chk_cmd("ld.idle", 1'b0, 32'h0, 32'h0, 4'h0);

    // FIFO fill under backpressure, fifth push dropped
    dram_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = 32'(4 * i); wr_wdata = 32'hA0 + 32'(i); wr_be = 4'hF;
      #1;
      chk($sformatf("fill.full%0d", i), 64'(wr_full), 64'(i == 4));
      chk($sformatf("fill.oe%0d", i), 64'(dram_oe), 64'd0);
      tick();
    end
    wr_req = 1'b0;
    #1;
    chk("fill.err", 64'(err), 64'd1);
    chk("fill.full", 64'(wr_full), 64'd1);
    dram_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cmd($sformatf("drain%0d", i), 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      tick();
    end
    chk_cmd("drain.end", 1'b0, 32'h0, 32'h0, 4'h0);
    chk("drain.full", 64'(wr_full), 64'd0);

    // Reset clears sticky error
    rst_x = 1'b0;
    #1;
    chk("rst2.err", 64'(err), 64'd0);
    tick();
    rst_x = 1'b1;
    tick();

    // Read behind two stores
    dram_busy = 1'b1;
    wr_req = 1'b1; wr_addr = 32'h300; wr_wdata = 32'h1; wr_be = 4'hF;
    tick();
    wr_addr = 32'h304; wr_wdata = 32'h2; wr_be = 4'hC;
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 32'h40;
    tick();
    rd_req = 1'b0; dram_busy = 1'b0;
    #1;
    chk("rbw.busy", 64'(busy), 64'd1);
    chk_cmd("rbw.w0", 1'b1, 32'h300, 32'h1, 4'hF);
    tick();
    chk_cmd("rbw.w1", 1'b1, 32'h304, 32'h2, 4'hC);
    tick();
    chk_cmd("rbw.rd", 1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    chk_cmd("rbw.wait0", 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rbw.busy0", 64'(busy), 64'd1);
    chk("rbw.fv0", 64'(fill_valid), 64'd0);
    tick();
    chk("rbw.busy1", 64'(busy), 64'd1);
    dram_valid = 1'b1; dram_rdata = 32'h12345678;
    #1;
    chk("rbw.fv", 64'(fill_valid), 64'd1);
    chk("rbw.faddr", 64'(fill_addr), 64'h40);
    chk("rbw.fdata", 64'(fill_rdata), 64'h12345678);
    tick();
    dram_valid = 1'b0;
    #1;
    chk("rbw.busy.end", 64'(busy), 64'd0);
    chk("rbw.fv.end", 64'(fill_valid), 64'd0);
    chk("rbw.err", 64'(err), 64'd0);

    // Stores posted during RD_WAIT
    rd_req = 1'b1; rd_addr = 32'h80;
    tick();
    rd_req = 1'b0;
    #1;
    chk_cmd("rw.rd", 1'b1, 32'h80, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = 32'h500 + 32'(4 * i); wr_wdata = 32'hB0 + 32'(i); wr_be = 4'h1;
      #1;
      chk($sformatf("rw.hold%0d", i), 64'(dram_oe), 64'd0);
      tick();
    end
    wr_req = 1'b0; dram_valid = 1'b1; dram_rdata = 32'hCAFE0001;
    #1;
    chk("rw.hold3", 64'(dram_oe), 64'd0);
    chk("rw.fv", 64'(fill_valid), 64'd1);
    chk("rw.faddr", 64'(fill_addr), 64'h80);
    tick();
    dram_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cmd($sformatf("rw.st%0d", i), 1'b1, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 4'h1);
      tick();
    end
    chk_cmd("rw.end", 1'b0, 32'h0, 32'h0, 4'h0);

    // rd_req while busy is ignored and flags an error
    rd_req = 1'b1; rd_addr = 32'h90;
    tick();
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 32'h99;
    tick();
    rd_req = 1'b0;
    #1;
    chk("dup.err", 64'(err), 64'd1);
    dram_valid = 1'b1; dram_rdata = 32'h5;
    #1;
    chk("dup.faddr", 64'(fill_addr), 64'h90);
    tick();
    dram_valid = 1'b0;
    #1;
    chk("dup.busy", 64'(busy), 64'd0);

    // Reset in the middle of a read with a store queued
    rst_x = 1'b0;
    tick();
    rst_x = 1'b1;
    tick();
    rd_req = 1'b1; rd_addr = 32'hC0;
    tick();
    rd_req = 1'b0;
    tick();
    wr_req = 1'b1; wr_addr = 32'h600; wr_wdata = 32'h7; wr_be = 4'hF;
    tick();
    wr_req = 1'b0;
    rst_x = 1'b0;
    #1;
    chk("mid.rst.busy", 64'(busy), 64'd0);
    chk("mid.rst.err", 64'(err), 64'd0);
    tick();
    rst_x = 1'b1;
    dram_valid = 1'b1; dram_rdata = 32'hBAD0BAD0;
    #1;
    chk("mid.fv", 64'(fill_valid), 64'd0);
    chk("mid.oe", 64'(dram_oe), 64'd0);
    tick();
    dram_valid = 1'b0;
    #1;
    chk("mid.err", 64'(err), 64'd1);
    chk("mid.busy", 64'(busy), 64'd0);
    chk("mid.oe2", 64'(dram_oe), 64'd0);
    chk("mid.full", 64'(wr_full), 64'd0);

    // Backpressure on a pending read
    dram_busy = 1'b1; rd_req = 1'b1; rd_addr = 32'hE0;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp.oe%0d", i), 64'(dram_oe), 64'd0);
      tick();
    end
    dram_busy = 1'b0;
    #1;
    chk_cmd("bp.rd", 1'b1, 32'hE0, 32'h0, 4'h0);
    tick();
    dram_valid = 1'b1; dram_rdata = 32'h0BADF00D;
    #1;
    chk("bp.fdata", 64'(fill_rdata), 64'h0BADF00D);
    tick();
    dram_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
